// File: rtl/clk_div_pkg.sv
// Shared helpers for the clock-divider bank.
// Provides the channel-index width derivation used by the port lists.
package clk_div_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  // A single channel still needs a 1-bit select port.
  function automatic int unsigned ch_idx_w(input int unsigned n_ch);
    return (n_ch <= 1) ? 1 : clog2(n_ch);
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, active/pending divisor and
// registered divided-clock and tick outputs.
module clk_div_ch #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50_000_000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_div,
  output logic             div_out,
  output logic             tick,
  output logic             pend
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div_act;
  logic [WIDTH-1:0] r_div_pend;
  logic             r_pend_valid;
  logic             r_out;
  logic             r_tick;

  logic             w_stopped;
  logic             w_wrap;
  logic             w_apply;
  logic [WIDTH-1:0] w_half;

  assign w_stopped = (r_div_act == '0);
  // Compare with >= so an out-of-range count still wraps cleanly.
  assign w_wrap    = !w_stopped && (r_cnt >= r_div_act - WIDTH'(1));
  // ceil(div/2) written without an overflowing div+1.
  assign w_half    = (r_div_act >> 1) + WIDTH'(r_div_act[0]);
  assign w_apply   = r_pend_valid && (sync || w_stopped || (en && w_wrap));

  // NOTE: non-blocking assignments mean every reference below sees the
  // pre-edge value, so an apply always consumes the old pending divisor even
  // when a new write lands in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_div_act    <= DEFAULT_DIV;
      r_pend_valid <= 1'b0;
      r_out        <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      if (sync || w_stopped) begin
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
      end else if (en) begin
        r_tick <= (r_cnt == '0);
        r_out  <= (r_cnt < w_half);
        r_cnt  <= w_wrap ? '0 : r_cnt + WIDTH'(1);
      end else begin
        r_tick <= 1'b0;
      end

      if (w_apply) r_div_act <= r_div_pend;

      if (wr_en)        r_pend_valid <= 1'b1;
      else if (w_apply) r_pend_valid <= 1'b0;
    end
  end

  // NOTE: the pending divisor carries no reset; it is only ever read while
  // r_pend_valid is set, and that flag is reset.
  always_ff @(posedge clk) begin
    if (wr_en) r_div_pend <= wr_div;
  end

  assign div_out = r_out;
  assign tick    = r_tick;
  assign pend    = r_pend_valid;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers on one system clock.
// Only the write-channel decode lives here; all state is per channel.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned      N_CH        = 4,
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(50_000_000)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             en,
  input  logic                        sync,
  input  logic                        wr_en,
  input  logic [ch_idx_w(N_CH)-1:0]   wr_ch,
  input  logic [WIDTH-1:0]            wr_div,
  output logic [N_CH-1:0]             div_out,
  output logic [N_CH-1:0]             tick,
  output logic [N_CH-1:0]             pend
);

  localparam int unsigned CH_W = ch_idx_w(N_CH);

  logic [N_CH-1:0] w_wr_sel;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    // Indices >= N_CH match no channel, so such writes are dropped.
    assign w_wr_sel[gi] = wr_en && (wr_ch == CH_W'(gi));

    clk_div_ch #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[gi]),
      .sync    (sync),
      .wr_en   (w_wr_sel[gi]),
      .wr_div  (wr_div),
      .div_out (div_out[gi]),
      .tick    (tick[gi]),
      .pend    (pend[gi])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: a cycle model predicts each output
// vector as stimulus is driven; predictions are queued and popped per cycle.
module tb_clk_div_bank;

  localparam int N_CH = 3;
  localparam int WIDTH = 8;
  localparam int DEF_DIV = 4;
  localparam int CH_W = 2;

  typedef struct packed {
    logic [N_CH-1:0] div_out;
    logic [N_CH-1:0] tick;
    logic [N_CH-1:0] pend;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [WIDTH-1:0] wr_div;
  logic [N_CH-1:0]  div_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pend;

  clk_div_bank #(
    .N_CH        (N_CH),
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (WIDTH'(DEF_DIV))
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
    .div_out (div_out),
    .tick    (tick),
    .pend    (pend)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  exp_t sb_q[$];

  // Reference model state, one entry per channel.
  int m_cnt [N_CH];
  int m_act [N_CH];
  int m_pdiv[N_CH];
  bit m_pv  [N_CH];
  bit m_out [N_CH];
  bit m_tick[N_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_cycle();
    exp_t e;
    for (int i = 0; i < N_CH; i++) begin
      bit wr, apply;
      wr    = wr_en && (int'(wr_ch) == i);
      apply = 1'b0;
      if (rst) begin
        m_cnt[i] = 0; m_act[i] = DEF_DIV; m_pv[i] = 1'b0;
        m_out[i] = 1'b0; m_tick[i] = 1'b0;
      end else begin
        if (sync || m_act[i] == 0) begin
          m_out[i] = 1'b0; m_tick[i] = 1'b0; m_cnt[i] = 0;
          apply = m_pv[i];
        end else if (en[i]) begin
          m_tick[i] = (m_cnt[i] == 0);
          m_out[i]  = (2 * m_cnt[i] < m_act[i]);
          if (m_cnt[i] + 1 == m_act[i]) begin
            m_cnt[i] = 0;
            apply = m_pv[i];
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end else begin
          m_tick[i] = 1'b0;
        end
        if (apply) begin
          m_act[i] = m_pdiv[i];
          m_pv[i]  = 1'b0;
        end
        if (wr) begin
          m_pdiv[i] = int'(wr_div);
          m_pv[i]   = 1'b1;
        end
      end
      e.div_out[i] = m_out[i];
      e.tick[i]    = m_tick[i];
      e.pend[i]    = m_pv[i];
    end
    sb_q.push_back(e);
  endtask

  // One clock: predict, clock the DUT, compare just after the edge.
  task automatic step();
    exp_t e;
    model_cycle();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("div_out", 32'(div_out), 32'(e.div_out));
      check("tick",    32'(tick),    32'(e.tick));
      check("pend",    32'(pend),    32'(e.pend));
    end
    wr_en = 1'b0;
    sync  = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write(input int ch, input int d);
    wr_en  = 1'b1;
    wr_ch  = CH_W'(ch);
    wr_div = WIDTH'(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    for (int i = 0; i < N_CH; i++) m_pdiv[i] = 0;
    en = '1;
    run(3);
    check("rst_div_out", 32'(div_out), 32'd0);
    check("rst_tick",    32'(tick),    32'd0);
    check("rst_pend",    32'(pend),    32'd0);

    // Free-running default divide-by-4: 1,1,0,0 with aligned ticks.
    rst = 1'b0;
    step();
    check("first_tick",    32'(tick),    32'h7);
    check("first_div_out", 32'(div_out), 32'h7);
    run(8);

    // Mid-period divisor change on ch0 (cnt=1 here).
    step();
    write(0, 3);
    step();
    check("pend_rise", 32'(pend[0]), 32'd1);
    run(12);

    // ch1 stopped by div=0, then restarted with div=5.
    write(1, 0);
    run(10);
    write(1, 5);
    run(16);

    // Stall ch0 for three cycles mid-period.
    while (m_cnt[0] != 2) step();
    en[0] = 1'b0;
    run(3);
    en[0] = 1'b1;
    run(10);

    // Write on the wrap cycle while an older value is still pending.
    write(0, 2);
    step();
    for (int k = 0; k < 20 && m_cnt[0] != m_act[0] - 1; k++) step();
    write(0, 5);
    run(14);

    // Out-of-range channel index must leave every channel untouched.
    write(3, 7);
    run(10);

    // Phase-aligned restart, with a simultaneous write kept pending.
    write(2, 6);
    step();
    run(2);
    sync = 1'b1;
    write(2, 3);
    step();
    check("sync_tick",    32'(tick),    32'd0);
    check("sync_div_out", 32'(div_out), 32'd0);
    step();
    check("sync_align", 32'(tick), 32'h7);
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Bank of N_CH independent programmable clock dividers sharing one system clock, with runtime-writable divisors and period-boundary reload. Each channel produces a ~50% duty divided clock and a one-cycle tick at every period start. Sits between the board clock and slow peripherals (display multiplex, button sampling, CPU single-step), replacing the fixed single-output divider.

## Interface

- N_CH, 4, number of divider channels (1..16)
- WIDTH, 32, divisor/counter width in bits
- DEFAULT_DIV, 50_000_000, divisor loaded into every channel at reset; must be < 2^WIDTH

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  N_CH  per-channel run enable
- sync  in  1  restart all channels phase-aligned
- wr_en  in  1  divisor write strobe
- wr_ch  in  max(1,clog2(N_CH))  target channel
- wr_div  in  WIDTH  new divisor value
- div_out  out  N_CH  divided clocks
- tick  out  N_CH  one-cycle pulse at period start
- pend  out  N_CH  channel has a written divisor not yet applied

## Operation

- Per channel: cnt (WIDTH), div_act, div_pend, pend_valid, out, tick registers.
- Reset (rst=1 at edge): cnt=0, div_act=DEFAULT_DIV, pend_valid=0, div_out=0, tick=0. pend=0. Reset has priority over everything.
- Write: wr_en=1 with wr_ch<N_CH sets div_pend=wr_div, pend_valid=1. wr_ch>=N_CH ignored. A second write before apply overwrites div_pend.
- Period: cnt counts 0..div_act-1 while en[i]=1, wraps to 0. At wrap (cnt==div_act-1, en=1), if pend_valid: div_act<=div_pend, pend_valid<=0.
- Outputs (registered from current cnt, en=1): tick<=(cnt==0); div_out<=(cnt < (div_act+1)>>1), i.e. high ceil(div/2) cycles, low floor(div/2).
- en[i]=0: cnt and div_out hold, tick<=0, pending write stays pending.
- div_act=0: channel stopped; cnt<=0, div_out<=0, tick<=0; any pending divisor applies on the next cycle (no boundary to wait for).
- div_act=1: tick and div_out high every enabled cycle.
- sync=1: every channel cnt<=0 and applies pending divisor immediately; tick/div_out<=0 that cycle; channels resume phase 0 next cycle if enabled.
- Simultaneous write and wrap on same channel: wrap consumes the old div_pend (if valid); the new write is captured and pending for the next wrap. Write with sync: sync applies the old pending value, new write stays pending.

## Timing

- Outputs lag cnt by 1 cycle. First enabled cycle after reset: tick=1, div_out=1 on the following cycle.
- Period of div_out and tick = div_act enabled cycles exactly; no drift, no extra reload cycle.
- Write-to-effect: applies at end of the current period, max latency div_act cycles + 1.
- pend[i] = pend_valid, registered, rises the cycle after write, falls the cycle after apply.

## Structure

- Shared header clk_div_pkg: clog2 function, WIDTH-independent constants (channel-index width derivation).
- One sub-module clk_div_ch: one channel (counter, active/pending divisor, output regs); bank instantiates N_CH via generate and decodes wr_ch to per-channel write strobes.
- Bank top has no state of its own beyond decode.

## Test plan

- Reset, N_CH=2, DEFAULT_DIV=4, en=2'b11 -> div_out pattern 1,1,0,0 repeating, tick every 4 cycles, both channels aligned; all outputs 0 during rst.
- Write ch0 div=3 mid-period (cnt=1) -> pend[0]=1 next cycle, old period of 4 completes, then div_out 1,1,0 repeating, pend[0] clears after apply.
- Write ch1 div=0 -> after current period div_out[1]=0, tick[1]=0 permanently; then write div=5 -> applies next cycle, tick[1] every 5 cycles, high 3/low 2.
- en[0] dropped for 3 cycles at cnt=2 of div=4 -> div_out[0] frozen, no tick; resumes with cnt=2, total period stretched by exactly 3.
- Write arriving same cycle as wrap with older pending value -> old value applied, new value applied at following wrap; wr_ch=N_CH write -> no channel changes.
- sync asserted with channels at different phases -> one cycle of zero outputs, then all channels tick together.
